// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: pattern type, blank pattern, bit order, hex decode.
// Latency: none (types, constants and a pure function).
// Backpressure: not applicable.
package seg7_pkg;

    // Segment pattern, MSB = segment A ... LSB = segment G, active-low (0 lights).
    typedef logic [6:0] seg7_t;

    // All segments dark in active-low form.
    localparam seg7_t SEG7_OFF = 7'b1111111;

    // Bit positions of each segment inside seg7_t.
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // Hex nibble to active-low segment pattern (b and d in lower case).
    function automatic seg7_t hex_to_seg7_f(input logic [3:0] nib);
        seg7_t pat;
        case (nib)
            4'h0:    pat = 7'b0000001;
            4'h1:    pat = 7'b1001111;
            4'h2:    pat = 7'b0010010;
            4'h3:    pat = 7'b0000110;
            4'h4:    pat = 7'b1001100;
            4'h5:    pat = 7'b0100100;
            4'h6:    pat = 7'b0100000;
            4'h7:    pat = 7'b0001111;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0000100;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b1100000;
            4'hC:    pat = 7'b0110001;
            4'hD:    pat = 7'b1000010;
            4'hE:    pat = 7'b0110000;
            default: pat = 7'b0111000;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low segment decoder with a blank override.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows the inputs.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output seg7_t      seg_o
);

    // Blanked digits go fully dark; otherwise look up the hex glyph.
    always_comb begin
        seg_o = blank_i ? SEG7_OFF : hex_to_seg7_f(nibble_i);
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode 7-segment scanner with shadowed value, LZ blanking and dead cycle.
// Latency: outputs registered, 1 cycle from pre/idx/shadow state; load shows on a lit digit 1 edge later.
// Backpressure: none; load is always accepted, enable=0 freezes the scan and darkens the display.
module seven_seg_scanner
    import seg7_pkg::*;
#(
    parameter  int NUM_DIGITS  = 4,
    parameter  int REFRESH_DIV = 100000,
    parameter  int ACTIVE_LOW  = 1,
    localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    lz_blank,
    input  logic                    enable,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [IDX_W-1:0]        digit_idx
);

    localparam int                PRE_W    = $clog2(REFRESH_DIV);
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Internally everything is active-low; INV flips all pins for active-high boards.
    localparam logic                  INV     = (ACTIVE_LOW == 0);
    localparam seg7_t                 SEG_RST = SEG7_OFF ^ {7{INV}};
    localparam logic [NUM_DIGITS-1:0] AN_RST  = {NUM_DIGITS{~INV}};
    localparam logic                  DP_RST  = ~INV;

    // Scan state
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Shadow registers
    logic [4*NUM_DIGITS-1:0] val_q, val_d;
    logic [NUM_DIGITS-1:0]   dpsh_q, dpsh_d;

    // Output registers
    seg7_t                 seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;

    // Datapath intermediates
    logic [NUM_DIGITS-1:0] blank_vec;
    logic                  zero_run;
    logic [3:0]            nib_sel;
    logic                  blank_sel;
    logic                  dp_sel;
    seg7_t                 dec_seg;
    logic                  lit;
    logic [NUM_DIGITS-1:0] an_l;
    seg7_t                 seg_l;
    logic                  dp_l;

    // Shadow capture: value and dp requests are only sampled on load.
    always_comb begin
        val_d  = load ? value : val_q;
        dpsh_d = load ? dp_in : dpsh_q;
    end

    // Prescaler and digit index advance; both hold while disabled.
    always_comb begin
        pre_d = pre_q;
        idx_d = idx_q;
        if (enable) begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    // Leading-zero mask: digit i>0 blanks when it and every higher nibble are zero.
    always_comb begin
        blank_vec = '0;
        zero_run  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (val_q[4*i +: 4] == 4'h0);
            if (i != 0) begin
                blank_vec[i] = lz_blank & zero_run;
            end
        end
    end

    // Select the nibble, blank flag and dp request of the digit being scanned.
    always_comb begin
        nib_sel   = 4'h0;
        blank_sel = 1'b0;
        dp_sel    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_sel   = val_q[4*i +: 4];
                blank_sel = blank_vec[i];
                dp_sel    = dpsh_q[i];
            end
        end
    end

    hex_to_seg7 u_dec (
        .nibble_i (nib_sel),
        .blank_i  (blank_sel),
        .seg_o    (dec_seg)
    );

    // Build active-low pin values: dark during the dead cycle (pre=0) or when disabled.
    always_comb begin
        lit  = enable & (pre_q != '0);
        an_l = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (lit && (idx_q == IDX_W'(i))) begin
                an_l[i] = 1'b0;
            end
        end
        seg_l = lit ? dec_seg : SEG7_OFF;
        dp_l  = ~(lit & dp_sel);
    end

    // Apply board polarity to everything headed for the pins.
    always_comb begin
        an_d        = an_l ^ {NUM_DIGITS{INV}};
        seg_d       = seg_l ^ {7{INV}};
        dp_d        = dp_l ^ INV;
        digit_idx_d = idx_q;
    end

    // Scan state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            idx_q <= '0;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
        end
    end

    // Shadow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q  <= '0;
            dpsh_q <= '0;
        end else begin
            val_q  <= val_d;
            dpsh_q <= dpsh_d;
        end
    end

    // Output registers; reset leaves the display dark in the board's polarity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q        <= AN_RST;
            seg_q       <= SEG_RST;
            dp_q        <= DP_RST;
            digit_idx_q <= '0;
        end else begin
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            digit_idx_q <= digit_idx_d;
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = dp_q;
    assign digit_idx = digit_idx_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: active-low and active-high instances on shared stimulus.
// Latency: expectations assume 1-cycle registered outputs, 4-cycle slots, 4 digits.
// Backpressure: none; all checks sampled on the falling edge.
module tb_seven_seg_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;
    logic        lz_blank;
    logic        enable;

    logic [6:0]  seg,   seg_h;
    logic        dp,    dp_h;
    logic [3:0]  an,    an_h;
    logic [1:0]  digit_idx, digit_idx_h;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seven_seg_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1)) u_lo (
        .clk       (clk),
        .rst_n     (rst_n),
        .value     (value),
        .dp_in     (dp_in),
        .load      (load),
        .lz_blank  (lz_blank),
        .enable    (enable),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .digit_idx (digit_idx)
    );

    seven_seg_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(0)) u_hi (
        .clk       (clk),
        .rst_n     (rst_n),
        .value     (value),
        .dp_in     (dp_in),
        .load      (load),
        .lz_blank  (lz_blank),
        .enable    (enable),
        .seg       (seg_h),
        .dp        (dp_h),
        .an        (an_h),
        .digit_idx (digit_idx_h)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One output cycle: lit digit d with active-low glyph es and dp edp, or a dark cycle on index d.
    task automatic check_cycle(input string tag, input bit lit_e, input int d,
                               input logic [6:0] es, input logic edp);
        logic [3:0] ean, ean_h;
        logic [6:0] eseg, eseg_h;
        logic       edp_e, edp_h;
        logic [1:0] eidx;
        ean    = lit_e ? ~(4'b0001 << d) : 4'b1111;
        eseg   = lit_e ? es : 7'b1111111;
        edp_e  = lit_e ? edp : 1'b1;
        ean_h  = ~ean;
        eseg_h = ~eseg;
        edp_h  = ~edp_e;
        eidx   = d[1:0];
        check({tag, ".an"},    an,          ean);
        check({tag, ".seg"},   seg,         eseg);
        check({tag, ".dp"},    dp,          edp_e);
        check({tag, ".idx"},   digit_idx,   eidx);
        check({tag, ".an_h"},  an_h,        ean_h);
        check({tag, ".seg_h"}, seg_h,       eseg_h);
        check({tag, ".dp_h"},  dp_h,        edp_h);
        check({tag, ".idx_h"}, digit_idx_h, eidx);
    endtask

    // Full 16-cycle frame starting on digit 0's dead cycle; drops load after the first edge.
    task automatic frame(input string tag, input logic [27:0] segs, input logic [3:0] dps);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c == 0) load = 1'b0;
            check_cycle(tag, (c % 4) != 0, c / 4, segs[(c/4)*7 +: 7], dps[c/4]);
        end
    endtask

    localparam logic [27:0] S_FEDC = {7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001};
    localparam logic [27:0] S_BA98 = {7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000};
    localparam logic [27:0] S_7654 = {7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100};
    localparam logic [27:0] S_3210 = {7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001};
    localparam logic [27:0] S_0040 = {7'b1111111, 7'b1111111, 7'b1001100, 7'b0000001};
    localparam logic [27:0] S_0000 = {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001};
    localparam logic [27:0] S_1020 = {7'b1001111, 7'b0000001, 7'b0010010, 7'b0000001};
    localparam logic [27:0] S_0008 = {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000000};

    initial begin
        logic [27:0] s3210;
        s3210 = S_3210;

        // Reset with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            value    = 16'($urandom);
            dp_in    = 4'($urandom);
            load     = 1'($urandom);
            lz_blank = 1'($urandom);
            enable   = 1'($urandom);
            @(negedge clk);
        end
        check_cycle("rst", 1'b0, 0, 7'h00, 1'b1);

        // Release and run full-decode frames
        rst_n = 1'b1; enable = 1'b1; lz_blank = 1'b0; dp_in = 4'b0000;
        load = 1'b1; value = 16'hFEDC;
        frame("dec_FEDC", S_FEDC, 4'b1111);
        load = 1'b1; value = 16'hBA98;
        frame("dec_BA98", S_BA98, 4'b1111);
        load = 1'b1; value = 16'h7654;
        frame("dec_7654", S_7654, 4'b1111);
        load = 1'b1; value = 16'h3210;
        frame("dec_3210", S_3210, 4'b1111);

        // Enable freeze in the middle of digit 2's slot
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_cycle("en_pre", (c % 4) != 0, c / 4, s3210[(c/4)*7 +: 7], 1'b1);
        end
        enable = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_cycle("en_off", 1'b0, 2, 7'h00, 1'b1);
        end
        enable = 1'b1;
        @(negedge clk); check_cycle("en_res2a", 1'b1, 2, 7'b0010010, 1'b1);
        @(negedge clk); check_cycle("en_res2b", 1'b1, 2, 7'b0010010, 1'b1);
        @(negedge clk); check_cycle("en_dead3", 1'b0, 3, 7'h00, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); check_cycle("en_d3", 1'b1, 3, 7'b0000110, 1'b1);
        end

        // Load mid-slot on digit 0
        @(negedge clk); check_cycle("ld_dead0", 1'b0, 0, 7'h00, 1'b1);
        @(negedge clk); check_cycle("ld_old0a", 1'b1, 0, 7'b0000001, 1'b1);
        load = 1'b1; value = 16'h000A;
        @(negedge clk); check_cycle("ld_old0b", 1'b1, 0, 7'b0000001, 1'b1);
        load = 1'b0;
        @(negedge clk); check_cycle("ld_new0", 1'b1, 0, 7'b0001000, 1'b1);
        @(negedge clk); check_cycle("ld_dead1", 1'b0, 1, 7'h00, 1'b1);
        @(negedge clk); check_cycle("ld_d1a", 1'b1, 1, 7'b0000001, 1'b1);
        @(negedge clk); check_cycle("ld_d1b", 1'b1, 1, 7'b0000001, 1'b1);
        // Load on the edge where the slot wraps from digit 1 to digit 2
        load = 1'b1; value = 16'h0500;
        @(negedge clk); check_cycle("wr_d1c", 1'b1, 1, 7'b0000001, 1'b1);
        load = 1'b0;
        @(negedge clk); check_cycle("wr_dead2", 1'b0, 2, 7'h00, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); check_cycle("wr_d2", 1'b1, 2, 7'b0100100, 1'b1);
        end
        @(negedge clk); check_cycle("wr_dead3", 1'b0, 3, 7'h00, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); check_cycle("wr_d3", 1'b1, 3, 7'b0000001, 1'b1);
        end

        // Leading-zero suppression
        lz_blank = 1'b1;
        load = 1'b1; value = 16'h0040; dp_in = 4'b0100;
        frame("lz_0040", S_0040, 4'b1011);
        load = 1'b1; value = 16'h0000; dp_in = 4'b0000;
        frame("lz_0000", S_0000, 4'b1111);
        load = 1'b1; value = 16'h1020;
        frame("lz_1020", S_1020, 4'b1111);

        // Polarity and dp without blanking
        lz_blank = 1'b0;
        load = 1'b1; value = 16'h0008; dp_in = 4'b1001;
        frame("pol_0008", S_0008, 4'b0110);

        // Asynchronous reset in the middle of a lit slot
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
        end
        check_cycle("pre_arst", 1'b1, 1, 7'b0000001, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_cycle("arst", 1'b0, 0, 7'h00, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed driver for a bank of common-anode 7-segment digits. It captures a packed hex value on a load strobe and decodes one nibble per digit to segment patterns. It rotates the active anode at a programmable refresh rate, with a dead cycle at each slot boundary to stop ghosting. It sits between datapath/status logic and the board display pins and replaces the single-digit combinational converter.

## Interface
- `NUM_DIGITS`, 4: number of digits scanned, at least 1.
- `REFRESH_DIV`, 100000: clock cycles per digit slot, at least 2.
- `ACTIVE_LOW`, 1: 1 means segment, dp and anode outputs light on 0; 0 inverts all three.
- `clk` in 1: single system clock; every register is on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `value` in 4*NUM_DIGITS: packed hex digits; bits [3:0] are digit 0, the rightmost.
- `dp_in` in NUM_DIGITS: decimal-point request per digit.
- `load` in 1: captures `value` and `dp_in` into shadow registers.
- `lz_blank` in 1: enables leading-zero suppression.
- `enable` in 1: 0 forces all anodes off and freezes the scan.
- `seg` out 7: segment pattern; MSB is segment A, LSB is segment G.
- `dp` out 1: decimal point.
- `an` out NUM_DIGITS: one-hot anode select.
- `digit_idx` out clog2(NUM_DIGITS), minimum 1: index of the digit currently selected.

## Operation
- **Shadow registers.** When `load`=1 at a clock edge, `value` and `dp_in` are captured. Otherwise they hold. The display always reads the shadow registers and never the live inputs.
- **Prescaler.** `pre` counts 0..REFRESH_DIV-1 and then wraps. At the wrap, `idx` advances by 1. From NUM_DIGITS-1 it wraps to 0.
- **Decode, active-low form.** Hex digits map as follows:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
  - With ACTIVE_LOW=0, all outputs are bitwise inverted.
- **Leading-zero suppression.** When `lz_blank`=1, digit i>0 is blanked (segments off) if its nibble and every higher nibble are zero. Digit 0 is never blanked. The decimal point is unaffected by blanking: a blanked digit with `dp_in`[i]=1 keeps its anode active with only dp lit.
- **Dead cycle.** While `pre`=0, all anodes and segments are off.
- **Enable.** When `enable`=0, `pre` and `idx` hold, and anodes, segments and dp are off. Shadow loading continues. When `enable` returns to 1, the scan resumes from the held state.
- **Load during a slot.** A load in the middle of a slot takes effect on the currently lit digit on the next output cycle. There is no wait for a slot boundary.
- **Reset, asserted at any time.**
  - `pre`=0, `idx`=0, shadow value = 0, shadow dp = 0.
  - `an` all off, `seg`=off (1111111 when ACTIVE_LOW=1), `dp` off, `digit_idx`=0.

## Timing
- `an`, `seg`, `dp` and `digit_idx` are registered. They reflect the `pre`/`idx`/shadow state of the previous cycle, giving 1-cycle output latency.
- Load-to-pixel latency: a `load` at edge t changes the shadow register at t. A lit digit shows the new pattern at edge t+1.
- Each digit is lit for REFRESH_DIV-1 cycles per slot after one dead cycle. The full frame is NUM_DIGITS*REFRESH_DIV cycles.
- First cycle after reset release: `pre` 0→1 and outputs are still dark. Digit 0 is first lit at the second edge after release.
- Simultaneous `load` and slot wrap: both take effect at the same edge, and the new slot shows the new value.

## Structure
- Package `seg7_pkg` holds:
  - the hex-to-segment function (active-low patterns),
  - `SEG7_OFF`=7'b1111111,
  - the segment bit-order constants (A=6 .. G=0).
- Sub-module `hex_to_seg7` is combinational: nibble and blank in, 7-bit active-low pattern out. It is instantiated once on the muxed nibble.
- The top level holds the prescaler, the index counter, the shadow registers, the leading-zero mask generation and the output polarity/registers.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1 unless stated.
- **Reset.** Hold `rst_n`=0 for 3 cycles with random inputs -> `an`=1111, `seg`=1111111, `dp`=1, `digit_idx`=0. Assert `rst_n` mid-frame -> the same values immediately, with no clock needed.
- **Full decode.** `load` value=0xFEDC, then 0xBA98, 0x7654, 0x3210 -> each digit slot shows the listed pattern (e.g. digit 3 of 0xFEDC is 0111000). `an` cycles 1110→1101→1011→0111, each active for 3 of 4 cycles with 1111 in the dead cycle.
- **Leading-zero suppression.** `lz_blank`=1, value=0x0040, `dp_in`=0100 -> digit 3 blank with an active low and seg=1111111 but `dp` high (off), i.e. the whole slot is dark apart from the anode. Digit 2: seg=1111111, dp=0. Digit 1: 1001100. Digit 0: 0000001. With value=0x0000 only digit 0 shows 0000001.
- **Enable freeze.** Drop `enable` in the middle of digit 2's slot for 10 cycles -> `an`=1111 for the whole gap. On re-enable, digit 2 finishes its remaining cycles before `idx` advances.
- **Load timing.** Pulse `load` with value 0x000A while digit 0 is lit -> `seg` changes from the old pattern to 0001000 exactly one edge later. Load coinciding with a slot wrap -> the next digit shows the new nibble.
- **Polarity.** ACTIVE_LOW=0, value=0x0008 -> lit digit 0 shows `seg`=1111111, the active anode is 1, and after reset `an`=0000 and `seg`=0000000.
